// File: rtl/ibex_dummy_instr_burst_pkg.sv
// Shared types and encoding helpers for the dummy-instruction burst generator.
// Instruction types follow the LFSR type field; encodings are RV32 R-type OP.
package ibex_dummy_instr_burst_pkg;

  typedef enum logic [1:0] {
    DUMMY_ADD = 2'd0,
    DUMMY_MUL = 2'd1,
    DUMMY_DIV = 2'd2,
    DUMMY_AND = 2'd3
  } dummy_instr_e;

  typedef enum logic {
    DUMMY_COUNT = 1'b0,
    DUMMY_BURST = 1'b1
  } dummy_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_ADD    = 3'b000;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_AND    = 3'b111;

  // Starting at the LFSR-chosen type, take the first enabled type walking upwards (mod 4).
  function automatic dummy_instr_e dummy_type_sel(logic [1:0] start, logic [3:0] type_en);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (type_en[idx]) sel = idx;
    end
    return dummy_instr_e'(sel);
  endfunction

  function automatic logic [31:0] dummy_encode(dummy_instr_e typ, logic [4:0] rs2,
                                               logic [4:0] rs1);
    logic [6:0] funct7;
    logic [2:0] funct3;
    funct7 = FUNCT7_BASE;
    funct3 = FUNCT3_ADD;
    case (typ)
      DUMMY_MUL: funct7 = FUNCT7_MULDIV;
      DUMMY_DIV: begin
        funct7 = FUNCT7_MULDIV;
        funct3 = FUNCT3_DIV;
      end
      DUMMY_AND: funct3 = FUNCT3_AND;
      default:   ;
    endcase
    return {funct7, rs2, rs1, funct3, 5'h00, OPCODE_OP};
  endfunction

endpackage

// File: rtl/ibex_dummy_lfsr.sv
// Galois LFSR with XOR-accumulated seeding, a zero-lockup guard and synchronous setback.
// Seeding takes priority over stepping.
module ibex_dummy_lfsr #(
  parameter int unsigned      LfsrW       = 32,
  parameter logic [LfsrW-1:0] LfsrTaps    = 32'h80200003,
  parameter logic [LfsrW-1:0] DefaultSeed = 32'hACE1ACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             setback_i,
  input  logic             seed_en_i,
  input  logic [LfsrW-1:0] seed_i,
  input  logic             advance_i,
  output logic [LfsrW-1:0] lfsr_o
);

  logic [LfsrW-1:0] lfsr_q;
  logic [LfsrW-1:0] seed_q;
  logic [LfsrW-1:0] seed_d;
  logic [LfsrW-1:0] lfsr_step;

  assign seed_d    = seed_q ^ seed_i;
  assign lfsr_step = {1'b0, lfsr_q[LfsrW-1:1]} ^ (lfsr_q[0] ? LfsrTaps : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= DefaultSeed;
      seed_q <= '0;
    end else if (setback_i) begin
      lfsr_q <= DefaultSeed;
      seed_q <= '0;
    end else if (seed_en_i) begin
      seed_q <= seed_d;
      // An all-zero state would lock the LFSR, so fall back to the default seed.
      lfsr_q <= (seed_d == '0) ? DefaultSeed : seed_d;
    end else if (advance_i) begin
      lfsr_q <= lfsr_step;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ibex_dummy_instr_burst.sv
// Dummy-instruction generator for the IF stage: inserts pseudo-random R-type ALU/MD
// instructions after a masked random timeout, optionally as bursts of up to four.
module ibex_dummy_instr_burst
  import ibex_dummy_instr_burst_pkg::*;
#(
  parameter int unsigned      CntW        = 5,
  parameter int unsigned      LfsrW       = 32,
  parameter logic [LfsrW-1:0] LfsrTaps    = 32'h80200003,
  parameter logic [LfsrW-1:0] DefaultSeed = 32'hACE1ACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             setback_i,
  input  logic             dummy_instr_en_i,
  input  logic [CntW-1:0]  dummy_instr_mask_i,
  input  logic [3:0]       dummy_type_en_i,
  input  logic [1:0]       burst_len_max_i,
  input  logic             dummy_instr_seed_en_i,
  input  logic [LfsrW-1:0] dummy_instr_seed_i,
  input  logic             stat_clr_i,
  input  logic             fetch_valid_i,
  input  logic             id_in_ready_i,
  output logic             insert_dummy_instr_o,
  output logic [31:0]      dummy_instr_data_o,
  output logic [15:0]      dummy_insert_cnt_o
);

  logic [LfsrW-1:0] lfsr;
  logic [CntW-1:0]  lfsr_cnt;
  logic [4:0]       lfsr_op_a;
  logic [4:0]       lfsr_op_b;
  logic [1:0]       lfsr_type;
  logic [1:0]       lfsr_burst;

  dummy_state_e     state_q;
  logic [CntW-1:0]  cnt_q;
  logic [1:0]       remain_q;
  logic [15:0]      stat_q;

  logic [CntW-1:0]  threshold;
  logic [1:0]       blen;
  logic             valid_type;
  logic             insert;
  logic             accept;
  logic             cnt_en;

  ibex_dummy_lfsr #(
    .LfsrW      (LfsrW),
    .LfsrTaps   (LfsrTaps),
    .DefaultSeed(DefaultSeed)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .setback_i(setback_i),
    .seed_en_i(dummy_instr_seed_en_i),
    .seed_i   (dummy_instr_seed_i),
    .advance_i(accept),
    .lfsr_o   (lfsr)
  );

  assign lfsr_cnt   = lfsr[CntW-1:0];
  assign lfsr_op_a  = lfsr[CntW+4:CntW];
  assign lfsr_op_b  = lfsr[CntW+9:CntW+5];
  assign lfsr_type  = lfsr[CntW+11:CntW+10];
  assign lfsr_burst = lfsr[CntW+13:CntW+12];

  generate
    if (LfsrW > CntW + 14) begin : g_spare_bits
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^lfsr[LfsrW-1:CntW+14];
    end
  endgenerate

  assign valid_type = |dummy_type_en_i;
  assign threshold  = lfsr_cnt & dummy_instr_mask_i;
  assign blen       = lfsr_burst & burst_len_max_i;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    insert = 1'b0;
    case (state_q)
      DUMMY_COUNT: insert = dummy_instr_en_i & valid_type & (cnt_q == threshold);
      DUMMY_BURST: insert = dummy_instr_en_i & valid_type;
      default:     insert = 1'b0;
    endcase
  end

  assign accept = insert & id_in_ready_i;
  assign cnt_en = dummy_instr_en_i & id_in_ready_i & (fetch_valid_i | insert);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= DUMMY_COUNT;
      cnt_q    <= '0;
      remain_q <= '0;
    end else if (setback_i) begin
      state_q  <= DUMMY_COUNT;
      cnt_q    <= '0;
      remain_q <= '0;
    end else begin
      case (state_q)
        DUMMY_COUNT: begin
          if (cnt_en) cnt_q <= insert ? '0 : cnt_q + CntW'(1);
          // Burst length comes from the LFSR value that produced this dummy.
          if (accept && (blen != 2'd0)) begin
            state_q  <= DUMMY_BURST;
            remain_q <= blen;
          end
        end
        DUMMY_BURST: begin
          if (!(dummy_instr_en_i && valid_type)) begin
            state_q  <= DUMMY_COUNT;
            cnt_q    <= '0;
            remain_q <= '0;
          end else if (accept) begin
            if (remain_q == 2'd1) begin
              state_q  <= DUMMY_COUNT;
              cnt_q    <= '0;
              remain_q <= '0;
            end else begin
              remain_q <= remain_q - 2'd1;
            end
          end
        end
        default: state_q <= DUMMY_COUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (setback_i || stat_clr_i) begin
      stat_q <= '0;
    end else if (accept && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign insert_dummy_instr_o = insert;
  assign dummy_instr_data_o   = dummy_encode(dummy_type_sel(lfsr_type, dummy_type_en_i),
                                             lfsr_op_b, lfsr_op_a);
  assign dummy_insert_cnt_o   = stat_q;

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
// Self-checking bench for ibex_dummy_instr_burst: vector table, directed corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_ibex_dummy_instr_burst;

  localparam bit [31:0] TAPS = 32'h80200003;
  localparam bit [31:0] DEF  = 32'hACE1ACE1;

  logic        clk, rst, setback, en, seed_en, stat_clr, fetch, ready;
  logic [4:0]  mask;
  logic [3:0]  type_en;
  logic [1:0]  bmax;
  logic [31:0] seed;
  logic        insert;
  logic [31:0] data;
  logic [15:0] stat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [31:0] m_lfsr, m_seed, m_data;
  int        m_cnt, m_left, m_stat;
  bit        m_ins;

  logic        last_ins;
  logic [31:0] last_data;
  logic [15:0] last_stat;
  logic [31:0] ref_stream [30];

  typedef struct {
    bit       en;
    bit [4:0] mask;
    bit [3:0] type_en;
    bit       exp_ins;
    int       exp_stat;
  } vec_t;
  vec_t tbl [10];

  ibex_dummy_instr_burst dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .setback_i            (setback),
    .dummy_instr_en_i     (en),
    .dummy_instr_mask_i   (mask),
    .dummy_type_en_i      (type_en),
    .burst_len_max_i      (bmax),
    .dummy_instr_seed_en_i(seed_en),
    .dummy_instr_seed_i   (seed),
    .stat_clr_i           (stat_clr),
    .fetch_valid_i        (fetch),
    .id_in_ready_i        (ready),
    .insert_dummy_instr_o (insert),
    .dummy_instr_data_o   (data),
    .dummy_insert_cnt_o   (stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = DEF;
    m_seed = 0;
    m_cnt  = 0;
    m_left = 0;
    m_stat = 0;
  endtask

  // Outputs implied by the current model state and the present inputs.
  task automatic model_comb();
    int t0, sel, opa, opb, f7, f3;
    bit found;
    bit timeout_hit;
    timeout_hit = (m_cnt == int'(m_lfsr[4:0] & mask));
    m_ins = en && (type_en != 0) && ((m_left > 0) || timeout_hit);
    t0 = int'((m_lfsr >> 15) & 3);
    sel = t0;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && type_en[(t0 + k) % 4]) begin
        sel = (t0 + k) % 4;
        found = 1;
      end
    end
    opa = int'((m_lfsr >> 5) & 31);
    opb = int'((m_lfsr >> 10) & 31);
    f7 = (sel == 1 || sel == 2) ? 1 : 0;
    f3 = (sel == 2) ? 4 : ((sel == 3) ? 7 : 0);
    m_data = 32'(f7 * (1 << 25) + opb * (1 << 20) + opa * (1 << 15) + f3 * (1 << 12) + 'h33);
  endtask

  task automatic model_update();
    bit acc;
    int blen;
    if (setback) begin
      model_reset();
      return;
    end
    acc  = m_ins && ready;
    blen = int'((m_lfsr >> 17) & 3) & int'(bmax);
    if (m_left == 0) begin
      if (en && ready && (fetch || m_ins)) m_cnt = m_ins ? 0 : (m_cnt + 1) % 32;
      if (acc) m_left = blen;
    end else if (!en || type_en == 0) begin
      m_left = 0;
      m_cnt  = 0;
    end else if (acc) begin
      m_left--;
      if (m_left == 0) m_cnt = 0;
    end
    if (seed_en) begin
      m_seed ^= seed;
      m_lfsr = (m_seed == 0) ? DEF : m_seed;
    end else if (acc) begin
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
    end
    if (stat_clr) m_stat = 0;
    else if (acc && m_stat < 65535) m_stat++;
  endtask

  // One clock: sample at the falling edge, compare with the model, then advance.
  task automatic tick(input bit cmp);
    @(negedge clk);
    model_comb();
    last_ins  = insert;
    last_data = data;
    last_stat = stat;
    if (cmp) begin
      check("model_insert", 32'(insert), 32'(m_ins));
      if (m_ins) check("model_data", data, m_data);
      check("model_stat", 32'(stat), 32'(m_stat));
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {setback, en, seed_en, stat_clr, fetch, ready} = '0;
    mask = '0; type_en = 4'hF; bmax = '0; seed = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_all_on(input bit [4:0] mk, input bit [1:0] bm);
    en = 1'b1; fetch = 1'b1; ready = 1'b1; type_en = 4'hF; mask = mk; bmax = bm;
  endtask

  // Advance until the model is about to start a run of at least min_len dummies.
  task automatic find_run(input int min_len, output int len, output bit ok);
    ok = 0;
    len = 0;
    for (int i = 0; i < 2000; i++) begin
      model_comb();
      if (m_left == 0 && m_ins) begin
        len = (int'((m_lfsr >> 17) & 3) & int'(bmax)) + 1;
        if (len >= min_len) begin
          ok = 1;
          break;
        end
      end
      tick(1);
    end
    if (!ok) check("find_run_timeout", 0, 1);
  endtask

  initial begin
    int n, len, cnt;
    bit ok;

    tbl[0] = '{1, 5'h00, 4'hF, 1, 0};
    tbl[1] = '{1, 5'h00, 4'hF, 1, 1};
    tbl[2] = '{1, 5'h00, 4'hF, 1, 2};
    tbl[3] = '{0, 5'h00, 4'hF, 0, 3};
    tbl[4] = '{1, 5'h00, 4'hF, 1, 3};
    tbl[5] = '{0, 5'h00, 4'hF, 0, 4};
    tbl[6] = '{1, 5'h00, 4'h1, 1, 4};
    tbl[7] = '{1, 5'h00, 4'hE, 1, 5};
    tbl[8] = '{1, 5'h00, 4'h0, 0, 6};
    tbl[9] = '{1, 5'h00, 4'h0, 0, 6};

    // Continuous insertion from reset, table-driven
    do_reset();
    drive_all_on(5'h00, 2'd0);
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; mask = tbl[i].mask; type_en = tbl[i].type_en;
      tick(1);
      check("tbl_insert", 32'(last_ins), 32'(tbl[i].exp_ins));
      check("tbl_stat", 32'(last_stat), 32'(tbl[i].exp_stat));
      if (tbl[i].exp_ins) check("tbl_data_low", 32'(last_data[11:0]), 32'h033);
    end

    // Seeded instruction: first dummy after 20 counted fetches
    do_reset();
    seed = 32'h00001234; seed_en = 1'b1;
    tick(1);
    check("reset_en0_insert", 32'(last_ins), 0);
    check("reset_stat", 32'(last_stat), 0);
    seed_en = 1'b0;
    drive_all_on(5'h1F, 2'd0);
    n = -1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (last_ins) begin
        n = i;
        break;
      end
    end
    check("seed_first_insert", n, 20);
    check("seed_data", last_data, 32'h00488033);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom % 8) != 0;
      mask     = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 4);
      type_en  = 4'($urandom);
      bmax     = 2'($urandom);
      fetch    = ($urandom % 4) != 0;
      ready    = ($urandom % 4) != 0;
      seed_en  = ($urandom % 64) == 0;
      seed     = $urandom;
      stat_clr = ($urandom % 128) == 0;
      setback  = ($urandom % 512) == 0;
      tick(1);
    end
    {seed_en, stat_clr, setback} = '0;

    // Type masking: ADD only, then no types enabled
    do_reset();
    drive_all_on(5'h03, 2'd3);
    type_en = 4'b0001;
    n = 0;
    for (int i = 0; i < 20000 && n < 200; i++) begin
      tick(1);
      if (last_ins) begin
        n++;
        check("type_add_only", 32'({last_data[31:25], last_data[14:12]}), 0);
      end
    end
    check("type_add_count", n, 200);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    type_en = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      mask = 5'($urandom);
      bmax = 2'($urandom);
      tick(1);
      cnt += int'(last_ins);
    end
    check("type_none_inserts", cnt, 0);
    check("type_none_stat", 32'(stat), 0);

    // Burst run lengths
    do_reset();
    drive_all_on(5'h00, 2'd3);
    for (int r = 0; r < 20; r++) begin
      find_run(1, len, ok);
      cnt = 0;
      for (int i = 0; i < len; i++) begin
        tick(1);
        cnt += int'(last_ins);
      end
      check("burst_run_len", cnt, len);
    end

    // Enable dropped mid-burst, then re-enabled with a full timeout mask
    find_run(3, len, ok);
    tick(1);
    tick(1);
    en = 1'b0;
    tick(1);
    check("drop_en_insert", 32'(last_ins), 0);
    en = 1'b1;
    mask = 5'h1F;
    len = int'(m_lfsr[4:0]);
    n = -1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (last_ins) begin
        n = i;
        break;
      end
    end
    check("reenable_timeout", n, len);

    // Zero seed reproduces the post-reset stream
    do_reset();
    drive_all_on(5'h00, 2'd0);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      ref_stream[i] = last_data;
    end
    do_reset();
    drive_all_on(5'h00, 2'd0);
    repeat (7) tick(1);
    en = 1'b0; seed = '0; seed_en = 1'b1;
    tick(1);
    seed_en = 1'b0; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      check("zero_seed_stream", last_data, ref_stream[i]);
    end

    // Setback in the middle of a burst
    do_reset();
    drive_all_on(5'h00, 2'd3);
    repeat (5) tick(1);
    find_run(3, len, ok);
    tick(1);
    setback = 1'b1;
    tick(1);
    setback = 1'b0;
    bmax = 2'd0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 0) check("setback_stat", 32'(last_stat), 0);
      check("setback_stream", last_data, ref_stream[i]);
    end

    // Saturation and clear-over-accept
    do_reset();
    drive_all_on(5'h00, 2'd0);
    repeat (65535) tick(0);
    tick(1);
    check("stat_saturated", 32'(last_stat), 32'h0000FFFF);
    tick(1);
    check("stat_holds", 32'(last_stat), 32'h0000FFFF);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    tick(1);
    check("stat_clr_wins", 32'(last_stat), 0);
    tick(1);
    check("stat_after_clr", 32'(last_stat), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_dummy_instr_burst.md
Name: ibex_dummy_instr_burst

Overview:
Parametrised dummy-instruction generator for the IF stage, used for secure code obfuscation. It inserts pseudo-random R-type ALU/MD instructions after a masked random timeout, optionally as bursts of 1-4 back-to-back dummies. It adds a per-type enable mask and a saturating insertion counter, and uses an internal Galois LFSR with a zero-lockup guard. It sits between the CSRs and the IF-stage instruction mux.

Parameters:
CntW, 5, timeout counter width (>=3)
LfsrW, 32, LFSR width; must be >= CntW+14
LfsrTaps, 32'h80200003, Galois feedback mask
DefaultSeed, 32'hACE1ACE1, LFSR reset/setback/zero-guard value (low LfsrW bits)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
setback_i  in  1  synchronous clear of all state to reset values
dummy_instr_en_i  in  1  global enable
dummy_instr_mask_i  in  CntW  AND-mask on the timeout threshold
dummy_type_en_i  in  4  per-type enable: bit0 ADD, bit1 MUL, bit2 DIV, bit3 AND
burst_len_max_i  in  2  AND-mask on the burst-extra field
dummy_instr_seed_en_i  in  1  seed strobe
dummy_instr_seed_i  in  LfsrW  seed value, XOR-accumulated
stat_clr_i  in  1  clear the insertion counter
fetch_valid_i  in  1  real instruction available
id_in_ready_i  in  1  ID accepts
insert_dummy_instr_o  out  1  dummy instruction valid this cycle
dummy_instr_data_o  out  32  dummy instruction encoding
dummy_insert_cnt_o  out  16  saturating count of accepted dummies

Behaviour:
- Reset or setback: lfsr_q=DefaultSeed; seed_q=0; cnt_q=0; state=COUNT; remain_q=0; stat_q=0.
- After reset, insert_dummy_instr_o is combinational and low whenever en=0.
- LFSR fields: cnt=[CntW-1:0]; op_a=[CntW+4:CntW]; op_b=[CntW+9:CntW+5]; type=[CntW+11:CntW+10]; burst=[CntW+13:CntW+12].
- Seeding: seed_d = seed_q ^ seed_i. On seed_en: seed_q<=seed_d; lfsr_q<= (seed_d==0) ? DefaultSeed : seed_d. Seeding has priority over advance.
- Accept = insert_o & id_in_ready_i. The LFSR advances one Galois step per accept: shift right; if old lsb is 1, XOR LfsrTaps.
- Type select: start at t=type. If type_en[t] is set, use t; otherwise take the first enabled of t+1, t+2, t+3 (mod 4). valid_type = |type_en.
- Encoding: {funct7, op_b, op_a, funct3, 5'h00, 7'h33}.
  - ADD: funct7 0000000, funct3 000
  - MUL: funct7 0000001, funct3 000
  - DIV: funct7 0000001, funct3 100
  - AND: funct7 0000000, funct3 111
- FSM COUNT:
  - threshold = cnt & mask_i.
  - insert_o = en & valid_type & (cnt_q==threshold).
  - cnt_en = en & ready & (fetch_valid | insert_o).
  - cnt_d = insert_o ? 0 : cnt_q+1, wrapping mod 2^CntW.
  - On accept: blen = burst & burst_len_max_i, sampled before the advance. If blen==0, stay in COUNT; else go to BURST with remain_q=blen.
- FSM BURST:
  - insert_o = en & valid_type.
  - Each accept uses fresh LFSR fields and decrements remain_q.
  - An accept with remain_q==1 returns to COUNT with cnt_q=0.
  - If en or valid_type drops: return to COUNT next cycle with cnt_q=0 and remain_q=0; insert_o is low that same cycle.
- With valid_type=0, no insertion occurs; the counter keeps wrapping.
- Stat counter: +1 per accept, saturates at 16'hFFFF. stat_clr_i wins over a same-cycle accept.
- Changing mask or type_en mid-operation takes effect combinationally; there is no latency.

Decomposition:
- ibex_pkg: dummy_instr_e (2-bit type), dummy_state_e {DUMMY_COUNT, DUMMY_BURST}, encoding constants.
- Sub-module ibex_dummy_lfsr: Galois LFSR with seed load, zero guard and setback, parametrised on LfsrW, LfsrTaps and DefaultSeed.

Test Plan:
- Continuous insertion: reset; en=1, mask=0, burst_max=0, type_en=F, ready=fetch_valid=1 -> insert_o high every cycle; stat counts 1,2,3...; data[6:0]=0x33 and data[11:7]=0.
- Seeded instruction: seed_i=32'h00001234, seed_en for 1 cycle; mask=1F, type_en=F -> first insert after 20 counted fetches; data=32'h00488033 (ADD, rs1=17, rs2=4).
- Type masking: type_en=4'b0001 for 200 inserts -> every data has funct7=0 and funct3=000. type_en=0 for 1000 cycles -> insert_o never high; stat stays 0.
- Burst: burst_max=3 -> each accept run length equals (burst&3)+1 from the LFSR model. Drop en mid-burst -> insert_o low same cycle. Re-enable -> state COUNT, cnt_q=0.
- Zero seed: seed_i=0 with seed_q=0 -> LFSR=DefaultSeed; instruction stream matches the post-reset stream.
- Setback mid-burst clears all state. Preload stat to FFFF via 65535 accepts -> it holds FFFF. stat_clr together with an accept -> 0.
